mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU's 2-read/1-write word memory interface.
//  Serves the fetch read port (0), the load read port (1) and the store write port.
//  Read data is registered (1-cycle latency), with write-first bypass.
//  A post-reset clear sequencer zeroes the array and raises ready; the top level
//  holds the CPU halted until ready is high.
// PARAMETERS
//  DEPTH           1024  words implemented; power of two, 2..32768
//  CLEAR_ON_RESET  1     1: zero the whole array after reset; 0: skip straight to RUN
// PORTS
//  clk       in   1   single clock, all state on posedge
//  rst_n     in   1   reset; synchronous, active-low
//  raddr0    in   15  [15:1] word address, fetch port
//  rdata0    out  16  read data for raddr0 from the previous cycle
//  raddr1    in   15  [15:1] word address, load port
//  rdata1    out  16  read data for raddr1 from the previous cycle
//  wen       in   1   write enable
//  waddr     in   15  [15:1] word write address
//  wdata     in   16  write data
//  ready     out  1   1 = RUN, requests are served
//  oob_err   out  1   sticky: an access in RUN hit an address >= DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at a posedge): state=CLEAR (or RUN if CLEAR_ON_RESET=0), clr_ptr=0,
//    rdata0=rdata1=16'h0000, ready=0, oob_err=0. Reset applies at any cycle, including
//    mid-clear; array contents are not reset directly.
//  - FSM: CLEAR -> RUN when clr_ptr==DEPTH-1 has been written. RUN holds until reset.
//    If CLEAR_ON_RESET=0, RUN is entered on the first posedge with rst_n=1.
//  - CLEAR: one word per cycle, mem[clr_ptr]<=0, clr_ptr++. Takes DEPTH cycles. wen is
//    ignored, rdata0/1 are forced to 0, and oob_err does not update.
//  - ready is registered: 1 exactly in cycles where the state is RUN.
//  - Read (RUN): rdataN at edge t+1 = mem[raddrN sampled at t]. Both ports are
//    independent, may carry the same address, and can be read in the same cycle.
//  - Write (RUN, wen=1): mem[waddr]<=wdata at edge t.
//  - Bypass: if wen && waddr==raddrN in the same cycle, rdataN gets wdata at t+1
//    (write-first). This applies per port and to both ports at once.
//  - Indexing: idx = addr[log2(DEPTH):1]. An address >= DEPTH is out of bounds.
//    An OOB read returns 16'h0000. An OOB write is dropped.
//    Any OOB read or write in RUN sets oob_err at t+1, and it stays set until reset.
//  - Out-of-bounds accesses are never bypassed, even when the addresses match.
//  - No backpressure: one write and two reads are accepted every RUN cycle.
// STRUCTURE
//  - Shared package (cpu_pkg): MEM_AW=15, WORD_W=16, and the state encoding
//    ST_CLEAR / ST_RUN.
//  - Sub-module mem_sram_2r1w: storage array only, with two synchronous read ports
//    and one write port, no reset.
//  - mem_responder contains the FSM, clr_ptr, the write-port mux (clear vs CPU),
//    the bypass compare, OOB detection, and the output registers.
// TESTING
//  1. DEPTH=16, CLEAR_ON_RESET=1; preload via backdoor, release rst_n
//     -> ready=0 for 16 cycles, then 1; every word reads 0.
//  2. RUN: write wdata=16'hBEEF, waddr=3; next cycle raddr0=3
//     -> rdata0=16'hBEEF one cycle later; rdata0 is 0 before the write.
//  3. Same cycle: wen=1, waddr=5, wdata=16'h1234, raddr0=raddr1=5
//     -> rdata0=rdata1=16'h1234 at the next edge.
//  4. DEPTH=16: write waddr=20, wdata=16'hFFFF, then read raddr1=20 and raddr1=4
//     -> oob_err=1 from the next cycle on; rdata1=0 for addr 20; mem[4] unchanged.
//  5. Assert rst_n=0 for one cycle at clr_ptr=7
//     -> ready=0, rdata=0, oob_err=0; clear restarts and ready rises 16 cycles after release.
//  6. CLEAR_ON_RESET=0
//     -> ready=1 the cycle after release; a wen during reset is dropped.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: memory interface widths and responder state encoding.
package cpu_pkg;

    localparam int unsigned MEM_AW = 15;
    localparam int unsigned WORD_W = 16;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // True when a word address falls outside an array of the given depth.
    function automatic logic addr_oob(input logic [MEM_AW-1:0] addr, input int unsigned depth);
        return {{(32 - MEM_AW){1'b0}}, addr} >= depth;
    endfunction

endpackage

// File: rtl/mem_sram_2r1w.sv
// Storage array with one write port and two synchronous read ports; no reset.
module mem_sram_2r1w #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr0,
    output logic [WORD_W-1:0] rdata0,
    input  logic [IDX_W-1:0]  raddr1,
    output logic [WORD_W-1:0] rdata1
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Reads return the pre-write contents; write-first is handled by the caller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata0 <= mem[raddr0];
        rdata1 <= mem[raddr1];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 2-read/1-write CPU word interface: post-reset clear,
// registered reads with write-first bypass, and sticky out-of-bounds detection.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MEM_AW-1:0] raddr0,
    output logic [WORD_W-1:0] rdata0,
    input  logic [MEM_AW-1:0] raddr1,
    output logic [WORD_W-1:0] rdata1,
    input  logic              wen,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic              oob_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              oob_err_q, oob_err_d;
    logic              zero0_q, zero0_d;
    logic              zero1_q, zero1_d;
    logic              byp0_q, byp0_d;
    logic              byp1_q, byp1_d;
    logic [WORD_W-1:0] byp_data_q, byp_data_d;

    logic              run;
    logic              oob_r0, oob_r1, oob_w;
    logic              clr_last;
    logic              sram_we;
    logic [IDX_W-1:0]  sram_waddr;
    logic [WORD_W-1:0] sram_wdata;
    logic [WORD_W-1:0] sram_rdata0, sram_rdata1;

    assign run      = (state_q == ST_RUN);
    assign oob_r0   = addr_oob(raddr0, DEPTH);
    assign oob_r1   = addr_oob(raddr1, DEPTH);
    assign oob_w    = addr_oob(waddr, DEPTH);
    assign clr_last = (clr_ptr_q == IDX_W'(DEPTH - 1));

    // Reset always lands in CLEAR so ready stays low through reset; with clearing
    // disabled, CLEAR is left on the first edge after release.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + IDX_W'(1);
            if (!CLEAR_ON_RESET || clr_last) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        sram_we    = 1'b0;
        sram_waddr = clr_ptr_q;
        sram_wdata = '0;
        if (state_q == ST_CLEAR) begin
            sram_we = rst_n && CLEAR_ON_RESET;
        end else begin
            sram_we    = rst_n && wen && !oob_w;
            sram_waddr = waddr[IDX_W-1:0];
            sram_wdata = wdata;
        end
    end

    // Address equality on the full address: a bypass hit implies an in-bounds read.
    always_comb begin
        zero0_d    = !run || oob_r0;
        zero1_d    = !run || oob_r1;
        byp0_d     = run && wen && !oob_w && (waddr == raddr0);
        byp1_d     = run && wen && !oob_w && (waddr == raddr1);
        byp_data_d = wdata;
        oob_err_d  = oob_err_q || (run && (oob_r0 || oob_r1 || (wen && oob_w)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            oob_err_q  <= 1'b0;
            zero0_q    <= 1'b1;
            zero1_q    <= 1'b1;
            byp0_q     <= 1'b0;
            byp1_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            oob_err_q  <= oob_err_d;
            zero0_q    <= zero0_d;
            zero1_q    <= zero1_d;
            byp0_q     <= byp0_d;
            byp1_q     <= byp1_d;
            byp_data_q <= byp_data_d;
        end
    end

    mem_sram_2r1w #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .WORD_W (WORD_W)
    ) u_sram (
        .clk    (clk),
        .we     (sram_we),
        .waddr  (sram_waddr),
        .wdata  (sram_wdata),
        .raddr0 (raddr0[IDX_W-1:0]),
        .rdata0 (sram_rdata0),
        .raddr1 (raddr1[IDX_W-1:0]),
        .rdata1 (sram_rdata1)
    );

    assign rdata0  = zero0_q ? '0 : (byp0_q ? byp_data_q : sram_rdata0);
    assign rdata1  = zero1_q ? '0 : (byp1_q ? byp_data_q : sram_rdata1);
    assign ready   = run;
    assign oob_err = oob_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: clear sequencing, reads, bypass, OOB and reset.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b;
    logic [14:0] raddr0, raddr1, waddr;
    logic        wen;
    logic [15:0] wdata;
    logic [15:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
    logic        ready_a, ready_b, oob_a, oob_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n_a),
        .raddr0  (raddr0),
        .rdata0  (rdata0_a),
        .raddr1  (raddr1),
        .rdata1  (rdata1_a),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .ready   (ready_a),
        .oob_err (oob_a)
    );

    mem_responder #(.DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n_b),
        .raddr0  (raddr0),
        .rdata0  (rdata0_b),
        .raddr1  (raddr1),
        .rdata1  (rdata1_b),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .ready   (ready_b),
        .oob_err (oob_b)
    );

    typedef struct {
        logic        wen;
        logic [14:0] waddr;
        logic [15:0] wdata;
        logic [14:0] ra0;
        logic [14:0] ra1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eoob;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr0 = '0;
        raddr1 = '0;
    endtask

    task automatic wait_ready_a(input string name);
        int cnt;
        cnt = 0;
        while (!ready_a && cnt < 40) begin
            step();
            cnt++;
        end
        chk(name, cnt, 16);
    endtask

    initial begin
        // rows are applied one per cycle; expectations are the outputs after that edge
        vecs[0]  = '{1'b0, 15'd0,  16'h0000, 15'd3,  15'd0,  16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 15'd3,  16'hBEEF, 15'd0,  15'd1,  16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 15'd0,  16'h0000, 15'd3,  15'd3,  16'hBEEF, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 15'd5,  16'h1234, 15'd5,  15'd5,  16'h1234, 16'h1234, 1'b0};
        vecs[4]  = '{1'b1, 15'd5,  16'h5555, 15'd5,  15'd3,  16'h5555, 16'hBEEF, 1'b0};
        vecs[5]  = '{1'b1, 15'd7,  16'hAAAA, 15'd2,  15'd7,  16'h0000, 16'hAAAA, 1'b0};
        vecs[6]  = '{1'b0, 15'd0,  16'h0000, 15'd5,  15'd7,  16'h5555, 16'hAAAA, 1'b0};
        vecs[7]  = '{1'b1, 15'd0,  16'h0001, 15'd15, 15'd0,  16'h0000, 16'h0001, 1'b0};
        vecs[8]  = '{1'b1, 15'd15, 16'hF00F, 15'd15, 15'd14, 16'hF00F, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 15'd4,  16'h4444, 15'd4,  15'd4,  16'h4444, 16'h4444, 1'b0};
        vecs[10] = '{1'b1, 15'd20, 16'hFFFF, 15'd0,  15'd4,  16'h0001, 16'h4444, 1'b1};
        vecs[11] = '{1'b0, 15'd0,  16'h0000, 15'd0,  15'd20, 16'h0001, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 15'd0,  16'h0000, 15'd15, 15'd4,  16'hF00F, 16'h4444, 1'b1};
        vecs[13] = '{1'b1, 15'd20, 16'h1111, 15'd20, 15'd4,  16'h0000, 16'h4444, 1'b1};
        vecs[14] = '{1'b0, 15'd0,  16'h0000, 15'd4,  15'd3,  16'h4444, 16'hBEEF, 1'b1};

        idle_inputs();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        step();
        step();
        chk("a_rst_ready", ready_a, 0);
        chk("a_rst_rdata0", rdata0_a, 0);
        chk("a_rst_rdata1", rdata1_a, 0);
        chk("a_rst_oob", oob_a, 0);
        chk("b_rst_ready", ready_b, 0);

        // no-clear instance, while dut_a stays in reset
        rst_n_b = 1'b1;
        step();
        chk("b_ready_after_release", ready_b, 1);
        wen = 1'b1; waddr = 15'd2; wdata = 16'h1357;
        step();
        idle_inputs();
        raddr0 = 15'd2;
        step();
        chk("b_rd_after_write", rdata0_b, 16'h1357);
        rst_n_b = 1'b0;
        wen = 1'b1; waddr = 15'd2; wdata = 16'hDEAD;
        step();
        chk("b_ready_in_reset", ready_b, 0);
        idle_inputs();
        rst_n_b = 1'b1;
        step();
        chk("b_ready_again", ready_b, 1);
        raddr0 = 15'd2;
        step();
        chk("b_wen_in_reset_dropped", rdata0_b, 16'h1357);
        idle_inputs();

        // clearing instance
        rst_n_a = 1'b1;
        wait_ready_a("a_clear_cycles");

        for (int i = 0; i < 15; i++) begin
            wen    = vecs[i].wen;
            waddr  = vecs[i].waddr;
            wdata  = vecs[i].wdata;
            raddr0 = vecs[i].ra0;
            raddr1 = vecs[i].ra1;
            step();
            chk($sformatf("vec%0d_rdata0", i), rdata0_a, vecs[i].e0);
            chk($sformatf("vec%0d_rdata1", i), rdata1_a, vecs[i].e1);
            chk($sformatf("vec%0d_oob", i), oob_a, vecs[i].eoob);
        end
        idle_inputs();

        // reset mid-clear while the array holds nonzero data
        rst_n_a = 1'b0;
        step();
        rst_n_a = 1'b1;
        repeat (7) step();
        chk("midclr_ready_before", ready_a, 0);
        rst_n_a = 1'b0;
        step();
        chk("midclr_rst_ready", ready_a, 0);
        chk("midclr_rst_rdata0", rdata0_a, 0);
        chk("midclr_rst_oob", oob_a, 0);
        rst_n_a = 1'b1;
        wait_ready_a("midclr_restart_cycles");

        for (int i = 0; i < 16; i++) begin
            raddr0 = 15'(i);
            raddr1 = 15'(15 - i);
            step();
            chk($sformatf("cleared_p0_%0d", i), rdata0_a, 0);
            chk($sformatf("cleared_p1_%0d", 15 - i), rdata1_a, 0);
        end

        // sticky OOB set by a read alone
        idle_inputs();
        step();
        chk("oob_clear_before", oob_a, 0);
        raddr0 = 15'd16;
        step();
        chk("oob_read_sets", oob_a, 1);
        chk("oob_read_data", rdata0_a, 0);
        raddr0 = 15'd1;
        step();
        chk("oob_sticky", oob_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
